// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and frame constants.
// Imported by the TX path and intended for a future RX path as well.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_MIN_DIV   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and a separate occupancy counter.
// Pointers are log2(DEPTH) bits and wrap naturally; DEPTH must be a power of 2.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     resetb,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic [LW-1:0]    level_d;
  logic [WIDTH-1:0] rd_data_q;
  logic             do_push;
  logic             do_pop;

  assign full_o    = (level_q == LW'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign rd_data_o = rd_data_q;

  // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    level_d = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rd_data_q <= '0;
    end else begin
      level_q <= level_d;
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        rd_data_q <= mem_q[rd_ptr_q];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter, LSB first, fed by a byte FIFO; bit time is a run-time
// clock divisor clamped to a minimum of 2 and latched once per frame.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clock,
  input  logic                          resetb,
  input  logic [DIV_WIDTH-1:0]          divisor,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int IDX_W = $clog2(UART_DATA_BITS);

  tx_state_e                 state_q, state_d;
  logic [DIV_WIDTH-1:0]      cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0]      div_q, div_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      tx_q, tx_d;
  logic [DIV_WIDTH-1:0]      div_eff;
  logic                      fifo_pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [UART_DATA_BITS-1:0] fifo_rd_data;

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .resetb    (resetb),
    .push_i    (tx_valid),
    .wr_data_i (tx_data),
    .pop_i     (fifo_pop),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level)
  );

  assign div_eff  = (divisor < DIV_WIDTH'(UART_MIN_DIV)) ? DIV_WIDTH'(UART_MIN_DIV) : divisor;
  assign tx_ready = !fifo_full;
  assign tx       = tx_q;
  assign busy     = (state_q != IDLE) || (fifo_level != '0);

  // The popped byte lands in the FIFO read register one edge after the pop, so
  // the shifter is loaded at the end of START, which always lasts at least 2 cycles.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    fifo_pop = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          div_d    = div_eff;
          cnt_d    = div_eff - 1'b1;
          state_d  = START;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          shift_d = fifo_rd_data;
          idx_d   = '0;
          cnt_d   = div_q - 1'b1;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
          cnt_d   = div_q - 1'b1;
          if (idx_q == IDX_W'(UART_DATA_BITS - 1)) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            div_d    = div_eff;
            cnt_d    = div_eff - 1'b1;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The line level is decoded from the next state so tx itself is a flop.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: table of single-frame vectors plus
// hand-written sequences for FIFO fill, divisor change, reset and push/pop overlap.
module tb_uart_tx_fifo;

  logic        clock = 1'b0;
  logic        resetb;
  logic [15:0] divisor;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx;
  logic        busy;
  logic [4:0]  fifo_level;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct {
    int         divIn;
    logic [7:0] data;
    int         effDiv;
    logic [9:0] expBits;
  } vec_t;

  vec_t vecs[4];

  uart_tx_fifo #(
    .FIFO_DEPTH (16),
    .DIV_WIDTH  (16)
  ) dut (
    .clock      (clock),
    .resetb     (resetb),
    .divisor    (divisor),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  // Called just after a negedge; returns at the next negedge, after the accepting edge.
  task automatic applyStimulus(input logic [7:0] data, output int accCyc);
    tx_valid = 1'b1;
    tx_data  = data;
    @(negedge clock);
    accCyc   = cyc;
    tx_valid = 1'b0;
  endtask

  task automatic waitUntil(input int target);
    int n = 0;
    while (cyc < target && n < 20000) begin
      @(negedge clock);
      n++;
    end
    if (cyc != target) checkOutput("waitUntil", cyc, target);
  endtask

  task automatic waitFall(input int limit, output int fallCyc, output bit ok);
    int n = 0;
    while (tx !== 1'b0 && n < limit) begin
      @(negedge clock);
      n++;
    end
    fallCyc = cyc;
    ok = (tx === 1'b0);
    if (!ok) checkOutput("fallTimeout", tx, 0);
  endtask

  // Samples each of the 10 bit slots in its middle; slot 0 is the start bit.
  task automatic captureFrame(input int d, output logic [9:0] frameBits, output int fallCyc, output bit ok);
    waitFall(400, fallCyc, ok);
    frameBits = '1;
    if (ok) begin
      repeat (d / 2) @(negedge clock);
      for (int i = 0; i < 10; i++) begin
        frameBits[i] = tx;
        if (i < 9) repeat (d) @(negedge clock);
      end
    end
  endtask

  initial begin
    logic [9:0] fb;
    int fc, fc2, acc, a2, a3, prev, zeros;
    bit ok;

    vecs[0] = '{868, 8'h37, 868, 10'b1001101110};
    vecs[1] = '{0,   8'hA5, 2,   10'b1101001010};
    vecs[2] = '{1,   8'h3C, 2,   10'b1001111000};
    vecs[3] = '{3,   8'hC1, 3,   10'b1110000010};

    resetb   = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    divisor  = 16'd868;
    repeat (3) @(negedge clock);
    checkOutput("resetTx", tx, 1);
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetLevel", fifo_level, 0);
    checkOutput("resetReady", tx_ready, 1);
    resetb = 1'b1;
    @(negedge clock);

    $display("[TB] single-frame vectors");
    for (int v = 0; v < 4; v++) begin
      divisor = 16'(vecs[v].divIn);
      applyStimulus(vecs[v].data, acc);
      captureFrame(vecs[v].effDiv, fb, fc, ok);
      checkOutput("latency", fc - acc, 1);
      checkOutput("frameBits", fb, vecs[v].expBits);
      waitUntil(fc + 10 * vecs[v].effDiv - 1);
      checkOutput("busyLastStop", busy, 1);
      checkOutput("txLastStop", tx, 1);
      @(negedge clock);
      checkOutput("busyDone", busy, 0);
    end

    $display("[TB] FIFO fill at divisor 4");
    divisor = 16'd4;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          checkOutput("readyFill", tx_ready, (i <= 16) ? 1 : 0);
          if (i == 17) checkOutput("levelFull", fifo_level, 16);
          tx_valid = 1'b1;
          tx_data  = 8'(i);
          @(negedge clock);
        end
        tx_valid = 1'b0;
      end
      begin
        prev = 0;
        for (int k = 0; k < 17; k++) begin
          captureFrame(4, fb, fc, ok);
          checkOutput("fifoData", fb, {1'b1, 8'(k), 1'b0});
          if (k > 0) checkOutput("frameSpacing", fc - prev, 40);
          prev = fc;
        end
      end
    join
    zeros = 0;
    repeat (60) begin
      @(negedge clock);
      if (tx !== 1'b1) zeros++;
    end
    checkOutput("noExtraFrame", zeros, 0);
    checkOutput("fillBusyDone", busy, 0);
    checkOutput("fillLevelDone", fifo_level, 0);

    $display("[TB] divisor change mid-frame");
    divisor = 16'd8;
    fork
      begin
        applyStimulus(8'h55, acc);
        applyStimulus(8'h33, a2);
        waitUntil(acc + 1 + 34);
        divisor = 16'd16;
      end
      begin
        captureFrame(8, fb, fc, ok);
        checkOutput("div8Bits", fb, {1'b1, 8'h55, 1'b0});
        captureFrame(16, fb, fc2, ok);
        checkOutput("div16Bits", fb, {1'b1, 8'h33, 1'b0});
        checkOutput("firstFrameLen", fc2 - fc, 80);
        waitUntil(fc2 + 159);
        checkOutput("div16BusyEnd", busy, 1);
        @(negedge clock);
        checkOutput("div16Done", busy, 0);
      end
    join

    $display("[TB] reset mid-frame");
    divisor = 16'd10;
    applyStimulus(8'h0F, acc);
    applyStimulus(8'hAA, a2);
    applyStimulus(8'h5A, a3);
    waitUntil(acc + 1 + 53);
    checkOutput("txBeforeReset", tx, 0);
    checkOutput("levelBeforeReset", fifo_level, 2);
    #2 resetb = 1'b0;
    #1;
    checkOutput("txAsyncReset", tx, 1);
    checkOutput("busyAsyncReset", busy, 0);
    checkOutput("levelAsyncReset", fifo_level, 0);
    checkOutput("readyAsyncReset", tx_ready, 1);
    @(negedge clock);
    resetb = 1'b1;
    zeros = 0;
    repeat (40) begin
      @(negedge clock);
      if (tx !== 1'b1) zeros++;
    end
    checkOutput("noFrameAfterReset", zeros, 0);
    checkOutput("busyAfterReset", busy, 0);

    $display("[TB] push and pop on the same edge");
    divisor = 16'd4;
    fork
      begin
        applyStimulus(8'h11, acc);
        applyStimulus(8'h22, a2);
        waitUntil(acc + 1 + 39);
        checkOutput("levelBeforeOverlap", fifo_level, 1);
        applyStimulus(8'h33, a3);
        checkOutput("levelAfterOverlap", fifo_level, 1);
        checkOutput("txStartSecond", tx, 0);
      end
      begin
        captureFrame(4, fb, fc, ok);
        checkOutput("overlapData0", fb, {1'b1, 8'h11, 1'b0});
        captureFrame(4, fb, fc2, ok);
        checkOutput("overlapData1", fb, {1'b1, 8'h22, 1'b0});
        checkOutput("overlapSpacing", fc2 - fc, 40);
        captureFrame(4, fb, fc, ok);
        checkOutput("overlapData2", fb, {1'b1, 8'h33, 1'b0});
        checkOutput("overlapSpacing2", fc - fc2, 40);
      end
    join
    waitUntil(fc + 40);
    checkOutput("overlapDone", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
